// File: rtl/crossbar_pkg.sv
// Shared types and defaults for the PMU event crossbar.
// Pure declarations: no logic and no latency.
// Optional feature macro used by the bundle: CROSSBAR_ACTIVITY_EN.
package crossbar_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_RISE  = 2'd1,
        MODE_FALL  = 2'd2,
        MODE_ANY   = 2'd3
    } mode_e;

    // Select field width carried by every config entry (covers N_IN up to 256).
    localparam int CFG_SEL_W     = 8;
    localparam int DEF_BLANK_CYC = 2;

    typedef struct packed {
        logic [CFG_SEL_W-1:0] sel;
        mode_e                mode;
    } cfg_entry_t;

    // Reset entry for output x: identity routing where the input exists, level mode.
    function automatic cfg_entry_t reset_entry(input int x, input int n_in);
        cfg_entry_t e;
        e.sel  = (x < n_in) ? CFG_SEL_W'(x) : '0;
        e.mode = MODE_LEVEL;
        return e;
    endfunction

endpackage

// File: rtl/crossbar_edge_det.sv
// One crossbar lane: source mux, sample/history registers and mode detection.
// Latency: 2 cycles from vector_i to out_o (sample stage, output stage).
// No backpressure; blank_i forces the registered output low while history keeps tracking.
module crossbar_edge_det
    import crossbar_pkg::*;
#(
    parameter int N_IN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_IN-1:0]      vector_i,
    input  logic [CFG_SEL_W-1:0] sel_i,
    input  mode_e                mode_i,
    input  logic                 blank_i,
    output logic                 out_o
);

    localparam int SEL_W = $clog2(N_IN);

    logic samp_q, samp_d;
    logic hist_q;
    logic out_q, out_d;

    // Source mux; selects past the last input read as a constant 0.
    always_comb begin
        samp_d = 1'b0;
        if (int'(sel_i) < N_IN) begin
            samp_d = vector_i[sel_i[SEL_W-1:0]];
        end
    end

    // Mode detection on the sampled value against the previous sample.
    always_comb begin
        out_d = 1'b0;
        unique case (mode_i)
            MODE_LEVEL: out_d = samp_q;
            MODE_RISE:  out_d = samp_q & ~hist_q;
            MODE_FALL:  out_d = ~samp_q & hist_q;
            MODE_ANY:   out_d = samp_q ^ hist_q;
            default:    out_d = 1'b0;
        endcase
        if (blank_i) begin
            out_d = 1'b0;
        end
    end

    // Sample, history and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= 1'b0;
            hist_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            samp_q <= samp_d;
            hist_q <= samp_q;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/crossbar_router.sv
// PMU event crossbar: routes N_IN event lines to N_OUT counters with per-output edge modes.
// Latency: 2 cycles input to vector_o; config takes effect on commit, then BLANK_CYC blanked cycles.
// No backpressure; CROSSBAR_ACTIVITY_EN adds sticky per-output activity flags with a clear input.
module crossbar_router
    import crossbar_pkg::*;
#(
    parameter int N_IN      = 32,
    parameter int N_OUT     = 24,
    parameter int BLANK_CYC = DEF_BLANK_CYC,
    localparam int SEL_W    = $clog2(N_IN),
    localparam int IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_IN-1:0]   vector_i,
    output logic [N_OUT-1:0]  vector_o,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [SEL_W-1:0]  cfg_sel_i,
    input  mode_e             cfg_mode_i,
    input  logic              cfg_commit_i,
    output logic              busy_o,
    output logic              commit_done_o
`ifdef CROSSBAR_ACTIVITY_EN
    ,
    input  logic              act_clr_i,
    output logic [N_OUT-1:0]  activity_o
`endif
);

    localparam int CNT_W = $clog2(BLANK_CYC + 1);

    cfg_entry_t        shadow_q [N_OUT];
    cfg_entry_t        shadow_d [N_OUT];
    cfg_entry_t        active_q [N_OUT];
    cfg_entry_t        active_d [N_OUT];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              blank_d;
    logic [N_OUT-1:0]  vec_out;

    // Shadow write; out-of-range indices match no entry and are dropped.
    always_comb begin
        for (int x = 0; x < N_OUT; x++) begin
            shadow_d[x] = shadow_q[x];
            if (cfg_we_i && (int'(cfg_idx_i) == x)) begin
                shadow_d[x].sel  = CFG_SEL_W'(cfg_sel_i);
                shadow_d[x].mode = cfg_mode_i;
            end
        end
    end

    // Commit copies the shadow, including any write landing in the same cycle.
    always_comb begin
        for (int x = 0; x < N_OUT; x++) begin
            active_d[x] = cfg_commit_i ? shadow_d[x] : active_q[x];
        end
    end

    // Blank counter: reload on every commit; done only when a countdown finishes undisturbed.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_commit_i) begin
            cnt_d = CNT_W'(BLANK_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        done_d  = !cfg_commit_i && (cnt_q == CNT_W'(1));
        blank_d = (cnt_d != '0);
    end

    // Config, blank counter and done-pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int x = 0; x < N_OUT; x++) begin
                shadow_q[x] <= reset_entry(x, N_IN);
                active_q[x] <= reset_entry(x, N_IN);
            end
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            for (int x = 0; x < N_OUT; x++) begin
                shadow_q[x] <= shadow_d[x];
                active_q[x] <= active_d[x];
            end
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Lanes sample through the next-state select so that, by the time blanking
    // lifts, both sample and history come from the newly committed source.
    // Output registers are blanked on the next-state count so vector_o is low
    // exactly while busy_o is high.
    for (genvar x = 0; x < N_OUT; x++) begin : g_lane
        crossbar_edge_det #(
            .N_IN (N_IN)
        ) u_det (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .vector_i (vector_i),
            .sel_i    (active_d[x].sel),
            .mode_i   (active_q[x].mode),
            .blank_i  (blank_d),
            .out_o    (vec_out[x])
        );
    end

    assign vector_o      = vec_out;
    assign busy_o        = (cnt_q != '0);
    assign commit_done_o = done_q;

`ifdef CROSSBAR_ACTIVITY_EN
    logic [N_OUT-1:0] act_q, act_d;

    // Sticky activity: a set in the same cycle as a clear takes priority.
    always_comb begin
        act_d = act_clr_i ? vec_out : (act_q | vec_out);
    end

    // Activity flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign activity_o = act_q;
`endif

endmodule

// File: tb/tb_crossbar_router.sv
// Scoreboard bench for crossbar_router: directed stimulus pushes expected outputs per cycle.
// A negedge monitor pops and compares entries due in the current cycle.
// Activity checks compile in when CROSSBAR_ACTIVITY_EN is defined.
module tb_crossbar_router;
    import crossbar_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] vec_in;
    logic [23:0] vector_o;
    logic        cfg_we;
    logic [4:0]  cfg_idx;
    logic [4:0]  cfg_sel;
    mode_e       cfg_mode;
    logic        cfg_commit;
    logic        busy_o;
    logic        commit_done_o;
`ifdef CROSSBAR_ACTIVITY_EN
    logic        act_clr;
    logic [23:0] activity_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [23:0] vec;
        logic        busy;
        logic        done;
        int          tag;
    } exp_t;

    exp_t sb_q[$];

    crossbar_router #(
        .N_IN      (32),
        .N_OUT     (24),
        .BLANK_CYC (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .vector_i      (vec_in),
        .vector_o      (vector_o),
        .cfg_we_i      (cfg_we),
        .cfg_idx_i     (cfg_idx),
        .cfg_sel_i     (cfg_sel),
        .cfg_mode_i    (cfg_mode),
        .cfg_commit_i  (cfg_commit),
        .busy_o        (busy_o),
        .commit_done_o (commit_done_o)
`ifdef CROSSBAR_ACTIVITY_EN
        ,
        .act_clr_i     (act_clr),
        .activity_o    (activity_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle, flag any that were skipped.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                n_checks++;
                if (sb_q[i].cyc < cyc) begin
                    n_errors++;
                    $display("FAIL sb_missed tag=%0d: due cycle %0d, now cycle %0d", sb_q[i].tag, sb_q[i].cyc, cyc);
                end else if (vector_o !== sb_q[i].vec || busy_o !== sb_q[i].busy || commit_done_o !== sb_q[i].done) begin
                    n_errors++;
                    $display("FAIL sb_out tag=%0d cyc=%0d: got vec=%h busy=%b done=%b, want vec=%h busy=%b done=%b",
                             sb_q[i].tag, cyc, vector_o, busy_o, commit_done_o, sb_q[i].vec, sb_q[i].busy, sb_q[i].done);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic exp_at(input int dly, input logic [23:0] v, input logic b, input logic d, input int tag);
        exp_t e;
        e.cyc  = cyc + dly;
        e.vec  = v;
        e.busy = b;
        e.done = d;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int idx, input int sel, input mode_e m);
        cfg_we   = 1'b1;
        cfg_idx  = 5'(idx);
        cfg_sel  = 5'(sel);
        cfg_mode = m;
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
    endtask

    // 3-cycle pulse on input 10; outputs 0..3 are LEVEL/RISE/FALL/ANY on input 10,
    // lvl holds every other output expected to follow input 10 as a level.
    task automatic pulse10(input logic [23:0] lvl, input int tag);
        vec_in = 32'h0000_0400;
        exp_at(1, 24'h000000,         1'b0, 1'b0, tag);
        exp_at(2, lvl | 24'h00000B,   1'b0, 1'b0, tag);
        exp_at(3, lvl | 24'h000001,   1'b0, 1'b0, tag);
        exp_at(4, lvl | 24'h000001,   1'b0, 1'b0, tag);
        exp_at(5, 24'h00000C,         1'b0, 1'b0, tag);
        exp_at(6, 24'h000000,         1'b0, 1'b0, tag);
        step(3);
        vec_in = 32'h0;
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        vec_in     = 32'h0;
        cfg_we     = 1'b0;
        cfg_idx    = 5'd0;
        cfg_sel    = 5'd0;
        cfg_mode   = MODE_LEVEL;
        cfg_commit = 1'b0;
`ifdef CROSSBAR_ACTIVITY_EN
        act_clr    = 1'b0;
`endif
        step(2);
        chk("reset_vector", 32'(vector_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_done", 32'(commit_done_o), 32'h0);

        // 1: default identity routing in level mode
        rst    = 1'b0;
        vec_in = 32'h0000_0005;
        exp_at(1, 24'h000000, 1'b0, 1'b0, 1);
        exp_at(2, 24'h000005, 1'b0, 1'b0, 1);
        exp_at(3, 24'h000005, 1'b0, 1'b0, 1);
        exp_at(4, 24'h000005, 1'b0, 1'b0, 1);
        step(4);

        // 2: shadow write alone does not reroute output 3
        wr(3, 31, MODE_RISE);
        vec_in = 32'h8000_0008;
        exp_at(2, 24'h000008, 1'b0, 1'b0, 2);
        exp_at(3, 24'h000008, 1'b0, 1'b0, 2);
        step(3);

        // 3: commit with input 31 held high: blank, one done pulse, no false rise
        vec_in     = 32'h8000_0000;
        cfg_commit = 1'b1;
        exp_at(1, 24'h000000, 1'b1, 1'b0, 3);
        exp_at(2, 24'h000000, 1'b1, 1'b0, 3);
        exp_at(3, 24'h000000, 1'b0, 1'b1, 3);
        exp_at(4, 24'h000000, 1'b0, 1'b0, 3);
        exp_at(5, 24'h000000, 1'b0, 1'b0, 3);
        step(1);
        cfg_commit = 1'b0;
        step(5);

        // 4: edge modes on a 3-cycle pulse
        vec_in = 32'h0;
        wr(0, 10, MODE_LEVEL);
        wr(1, 10, MODE_RISE);
        wr(2, 10, MODE_FALL);
        wr(3, 10, MODE_ANY);
        commit();
        step(4);
        pulse10(24'h000400, 4);

        // 5a: write to index 30 is ignored
        wr(30, 10, MODE_LEVEL);
        commit();
        step(4);
        pulse10(24'h000400, 5);

        // 5b: commit on the last blank cycle restarts blanking, single done
        cfg_commit = 1'b1;
        exp_at(1, 24'h000000, 1'b1, 1'b0, 6);
        exp_at(2, 24'h000000, 1'b1, 1'b0, 6);
        exp_at(3, 24'h000000, 1'b1, 1'b0, 6);
        exp_at(4, 24'h000000, 1'b1, 1'b0, 6);
        exp_at(5, 24'h000000, 1'b0, 1'b1, 6);
        exp_at(6, 24'h000000, 1'b0, 1'b0, 6);
        step(1);
        cfg_commit = 1'b0;
        step(1);
        cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
        step(4);

        // 5c: write and commit in the same cycle
        cfg_we     = 1'b1;
        cfg_idx    = 5'd5;
        cfg_sel    = 5'd10;
        cfg_mode   = MODE_LEVEL;
        cfg_commit = 1'b1;
        step(1);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        step(4);
        pulse10(24'h000420, 7);

        // 6: async reset mid-blanking
        commit();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_vector", 32'(vector_o), 32'h0);
        step(2);
        rst    = 1'b0;
        vec_in = 32'h0000_0401;
        exp_at(1, 24'h000000, 1'b0, 1'b0, 8);
        exp_at(2, 24'h000401, 1'b0, 1'b0, 8);
        exp_at(3, 24'h000401, 1'b0, 1'b0, 8);
        exp_at(4, 24'h000401, 1'b0, 1'b0, 8);
        step(5);

`ifdef CROSSBAR_ACTIVITY_EN
        chk("act_after_events", 32'(activity_o), 32'h0000_0401);
        vec_in = 32'h0;
        step(3);
        act_clr = 1'b1;
        step(1);
        act_clr = 1'b0;
        chk("act_cleared", 32'(activity_o), 32'h0);
        vec_in = 32'h0000_0001;
        step(3);
        chk("act_set", 32'(activity_o), 32'h0000_0001);
        act_clr = 1'b1;
        step(1);
        act_clr = 1'b0;
        chk("act_set_wins", 32'(activity_o), 32'h0000_0001);
        vec_in = 32'h0;
        step(2);
        act_clr = 1'b1;
        step(1);
        act_clr = 1'b0;
        chk("act_clear_idle", 32'(activity_o), 32'h0);
`endif

        step(3);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
